icache_responder: RTL

- Instruction-side responder for the single-cycle CPU fetch interface.
- Receives fetch requests (imemREN, imemaddr) from the program counter.
- Returns ihit and imemload.
- Backs them with a direct-mapped, one-word-per-frame cache that fills from RAM over a request/wait interface (iREN, iaddr, iwait, iload).

---
 rtl/icache_responder.sv | 116 +++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache between the CPU fetch port and RAM.
// A miss latches the word address and waits in FETCH until RAM drops iwait, then fills the frame.
module icache_responder #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        invalidate,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDXW;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StFetch = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [29:0]     miss_word_q, miss_word_d;
  logic [15:0]     hit_count_q, hit_count_d;
  logic [15:0]     miss_count_q, miss_count_d;
  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  logic [IDXW-1:0] req_idx, fill_idx;
  logic [TAGW-1:0] req_tag, fill_tag;
  logic            hit, miss_start, fill;
  logic [1:0]      unused_byte_offset;

  assign req_idx  = imemaddr[IDXW+1:2];
  assign req_tag  = imemaddr[31:IDXW+2];
  assign fill_idx = miss_word_q[IDXW-1:0];
  assign fill_tag = miss_word_q[29:IDXW];
  assign unused_byte_offset = imemaddr[1:0];

  assign hit        = (state_q == StIdle) & imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign miss_start = (state_q == StIdle) & imemREN & ~hit;
  // Invalidate aborts an in-flight fill so a stale word can never be installed.
  assign fill       = (state_q == StFetch) & ~iwait & ~invalidate;

  assign ihit       = hit;
  assign imemload   = hit ? data_q[req_idx] : 32'h0;
  assign iREN       = (state_q == StFetch);
  assign iaddr      = iREN ? {miss_word_q, 2'b00} : 32'h0;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d      = state_q;
    miss_word_d  = miss_word_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    unique case (state_q)
      StIdle: begin
        if (hit && hit_count_q != 16'hFFFF) begin
          hit_count_d = hit_count_q + 16'd1;
        end
        if (miss_start) begin
          state_d     = StFetch;
          miss_word_d = imemaddr[31:2];
          if (miss_count_q != 16'hFFFF) begin
            miss_count_d = miss_count_q + 16'd1;
          end
        end
      end
      StFetch: begin
        if (invalidate || !iwait) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      miss_word_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_word_q  <= miss_word_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else if (invalidate) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule
